// File: rtl/datapath_pkg.sv
// ============================================================================
// Module   : datapath_pkg
// Purpose  : Shared widths, register index map and ALU op codes for the
//            datapath_barramento slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package datapath_pkg;

   localparam int DEF_N     = 9;
   localparam int DEF_CNT_W = 16;

   localparam int R0_IDX = 0;
   localparam int R1_IDX = 1;
   localparam int R2_IDX = 2;
   localparam int R3_IDX = 3;
   localparam int R4_IDX = 4;
   localparam int R5_IDX = 5;
   localparam int R6_IDX = 6;
   localparam int R7_IDX = 7;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Rin/Rout are MSB-first: R0 sits on bit 7, R7 on bit 0.
   function automatic int sel_bit(input int idx);
      return 7 - idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/datapath_barramento_registrador_n.sv
// ============================================================================
// Module   : registrador_n
// Purpose  : N-bit register with load enable and synchronous active-high reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module registrador_n #(
   parameter int N = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [N-1:0] i_d,
   output logic [N-1:0] o_q
);

   logic [N-1:0] r_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/datapath_barramento.sv
// ============================================================================
// Module   : datapath_barramento
// Purpose  : R0..R7/A/G/IR datapath with a single priority bus, add/sub ALU
//            and a completed-instruction counter. Optional DATAPATH_BUS_CHECK_EN
//            adds a sticky BusErr flag for multi-source bus cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module datapath_barramento
   import datapath_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [N-1:0]     DIN,
   input  logic             IRin,
   input  logic [7:0]       Rin,
   input  logic [7:0]       Rout,
   input  logic             Ain,
   input  logic             Gin,
   input  logic             Gout,
   input  logic             AddSub,
   input  logic             DINout,
   input  logic             Done,
   output logic [N-1:0]     Instrucao,
   output logic [N-1:0]     Bus,
   input  logic [2:0]       DbgSel,
   output logic [N-1:0]     DbgData,
   output logic [CNT_W-1:0] InstrCount
`ifdef DATAPATH_BUS_CHECK_EN
   ,
   output logic             BusErr
`endif
);

   logic [N-1:0]     w_r [8];
   logic [N-1:0]     w_a;
   logic [N-1:0]     w_g;
   logic [N-1:0]     w_ir;
   logic [N-1:0]     w_bus;
   logic [N-1:0]     w_rout_val;
   logic [N-1:0]     w_alu;
   logic [CNT_W-1:0] r_instr_count;

   generate
      for (genvar i = R0_IDX; i <= R7_IDX; i++) begin : g_regs
         registrador_n #(.N(N)) u_reg (
            .clk    (Clock),
            .rst    (Reset),
            .i_load (Rin[sel_bit(i)]),
            .i_d    (w_bus),
            .o_q    (w_r[i])
         );
      end
   endgenerate

   registrador_n #(.N(N)) u_reg_a (
      .clk    (Clock),
      .rst    (Reset),
      .i_load (Ain),
      .i_d    (w_bus),
      .o_q    (w_a)
   );

   registrador_n #(.N(N)) u_reg_g (
      .clk    (Clock),
      .rst    (Reset),
      .i_load (Gin),
      .i_d    (w_alu),
      .o_q    (w_g)
   );

   registrador_n #(.N(N)) u_reg_ir (
      .clk    (Clock),
      .rst    (Reset),
      .i_load (IRin),
      .i_d    (DIN),
      .o_q    (w_ir)
   );

   // Scan from R7 up to R0 so the lowest-numbered register (highest bit) wins.
   always_comb begin
      w_rout_val = '0;
      for (int b = 0; b < 8; b++) begin
         if (Rout[b]) begin
            w_rout_val = w_r[7 - b];
         end
      end
   end

   always_comb begin
      if (DINout) begin
         w_bus = DIN;
      end else if (Gout) begin
         w_bus = w_g;
      end else begin
         w_bus = w_rout_val;
      end
   end

   assign w_alu = (AddSub == OP_SUB) ? (w_a - w_bus) : (w_a + w_bus);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_instr_count <= '0;
      end else if (Done) begin
         r_instr_count <= r_instr_count + 1'b1;
      end
   end

`ifdef DATAPATH_BUS_CHECK_EN
   logic [9:0] w_src;
   logic       w_multi;
   logic       r_bus_err;

   assign w_src   = {DINout, Gout, Rout};
   assign w_multi = |(w_src & (w_src - 10'd1));

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_bus_err <= 1'b0;
      end else if (w_multi) begin
         r_bus_err <= 1'b1;
      end
   end

   assign BusErr = r_bus_err;
`endif

   assign Bus        = w_bus;
   assign Instrucao  = w_ir;
   assign DbgData    = w_r[DbgSel];
   assign InstrCount = r_instr_count;

endmodule

`default_nettype wire

// File: tb/tb_datapath_barramento.sv
// ============================================================================
// Module   : tb_datapath_barramento
// Purpose  : Directed scoreboard bench for datapath_barramento (main instance
//            plus a CNT_W=2 instance for counter wrap).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_datapath_barramento;

   localparam int N = 9;

   logic         Clock = 1'b0;
   logic         Reset;
   logic [N-1:0] DIN;
   logic         IRin, Ain, Gin, Gout, AddSub, DINout, Done;
   logic [7:0]   Rin, Rout;
   logic [2:0]   DbgSel;
   logic [N-1:0] Instrucao, Bus, DbgData;
   logic [15:0]  InstrCount;
   logic [N-1:0] Instrucao2, Bus2, DbgData2;
   logic [1:0]   InstrCount2;
`ifdef DATAPATH_BUS_CHECK_EN
   logic         BusErr, BusErr2;
`endif

   always #50 Clock = ~Clock;

   datapath_barramento #(.N(N), .CNT_W(16)) dut (
      .Clock(Clock), .Reset(Reset), .DIN(DIN), .IRin(IRin), .Rin(Rin),
      .Rout(Rout), .Ain(Ain), .Gin(Gin), .Gout(Gout), .AddSub(AddSub),
      .DINout(DINout), .Done(Done), .Instrucao(Instrucao), .Bus(Bus),
      .DbgSel(DbgSel), .DbgData(DbgData), .InstrCount(InstrCount)
`ifdef DATAPATH_BUS_CHECK_EN
      , .BusErr(BusErr)
`endif
   );

   datapath_barramento #(.N(N), .CNT_W(2)) dut_w2 (
      .Clock(Clock), .Reset(Reset), .DIN(DIN), .IRin(IRin), .Rin(Rin),
      .Rout(Rout), .Ain(Ain), .Gin(Gin), .Gout(Gout), .AddSub(AddSub),
      .DINout(DINout), .Done(Done), .Instrucao(Instrucao2), .Bus(Bus2),
      .DbgSel(DbgSel), .DbgData(DbgData2), .InstrCount(InstrCount2)
`ifdef DATAPATH_BUS_CHECK_EN
      , .BusErr(BusErr2)
`endif
   );

   typedef struct {
      int          kind;
      int          sel;
      logic [15:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   localparam int K_BUS = 0, K_DBG = 1, K_IR = 2, K_CNT = 3, K_ERR = 4, K_CNT2 = 5;

   function automatic string kname(input int k);
      case (k)
         K_BUS:   return "Bus";
         K_DBG:   return "DbgData";
         K_IR:    return "Instrucao";
         K_CNT:   return "InstrCount";
         K_ERR:   return "BusErr";
         default: return "InstrCount_w2";
      endcase
   endfunction

   function automatic logic [15:0] observe(input int k);
      case (k)
         K_BUS:   return {7'd0, Bus};
         K_DBG:   return {7'd0, DbgData};
         K_IR:    return {7'd0, Instrucao};
         K_CNT:   return InstrCount;
`ifdef DATAPATH_BUS_CHECK_EN
         K_ERR:   return {15'd0, BusErr};
`endif
         default: return {14'd0, InstrCount2};
      endcase
   endfunction

   task automatic push(input int k, input int sel, input logic [15:0] e);
      exp_t item;
      item.kind = k;
      item.sel  = sel;
      item.exp  = e;
      sb.push_back(item);
   endtask

   task automatic push_err(input logic e);
`ifdef DATAPATH_BUS_CHECK_EN
      push(K_ERR, 0, {15'd0, e});
`else
      if (e === 1'bx) push(K_ERR, 0, 16'd0);
`endif
   endtask

   task automatic drain();
      exp_t        item;
      logic [15:0] obs;
      while (sb.size() > 0) begin
         item   = sb.pop_front();
         DbgSel = item.sel[2:0];
         #1;
         obs = observe(item.kind);
         n_assert++;
         assert (obs === item.exp) else begin
            n_fail++;
            $error("FAIL %s[%0d] observed=%h expected=%h", kname(item.kind), item.sel, obs, item.exp);
         end
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic idle();
      IRin = 0; Ain = 0; Gin = 0; Gout = 0; AddSub = 0; DINout = 0; Done = 0;
      Rin = 8'h00; Rout = 8'h00;
   endtask

   task automatic load_reg(input logic [7:0] rin, input logic [N-1:0] v);
      idle();
      DIN = v; DINout = 1; Rin = rin;
      tick();
      idle();
   endtask

   initial begin
      idle();
      DIN = 9'h1FF; DbgSel = 0; Reset = 1;
      IRin = 1; Rin = 8'hFF; DINout = 1; Ain = 1; Gin = 1; Done = 1;
      tick();
      idle();
      // Reset state (held in reset so enables stay overridden)
      Gout = 1;
      for (int i = 0; i < 8; i++) push(K_DBG, i, 16'd0);
      push(K_IR, 0, 16'd0);
      push(K_CNT, 0, 16'd0);
      push(K_BUS, 0, 16'd0);
      push_err(1'b0);
      drain();
      Reset = 0;
      idle();

      // 1: DIN onto bus, into R0
      DIN = 9'h055; DINout = 1; Rin = 8'b1000_0000;
      push(K_BUS, 0, 16'h055); drain();
      tick(); idle();
      push(K_DBG, 0, 16'h055); drain();

      // 2: mv R1 <- R0
      Rout = 8'b1000_0000; Rin = 8'b0100_0000;
      push(K_BUS, 0, 16'h055); drain();
      tick(); idle();
      push(K_DBG, 1, 16'h055); push(K_DBG, 0, 16'h055); drain();

      // 3: sub and add
      load_reg(8'b1000_0000, 9'h005);
      load_reg(8'b0100_0000, 9'h007);
      Ain = 1; Rout = 8'b1000_0000; tick(); idle();
      Rout = 8'b0100_0000; AddSub = 1; Gin = 1; tick(); idle();
      Gout = 1; Rin = 8'b1000_0000;
      push(K_BUS, 0, 16'h1FE); drain();
      tick(); idle();
      push(K_DBG, 0, 16'h1FE); drain();

      load_reg(8'b1000_0000, 9'h005);
      Ain = 1; Rout = 8'b1000_0000; tick(); idle();
      Rout = 8'b0100_0000; AddSub = 0; Gin = 1; tick(); idle();
      Gout = 1; Rin = 8'b1000_0000; tick(); idle();
      push(K_DBG, 0, 16'h00C); drain();

      // Gout with Gin: G <= A + old G = 5 + C
      Gout = 1; Gin = 1; tick(); idle();
      Gout = 1; push(K_BUS, 0, 16'h011); drain(); idle();
      // Ain with Gin: G uses old A (5), A becomes 3
      DIN = 9'h003; DINout = 1; Ain = 1; Gin = 1; tick(); idle();
      Gout = 1; push(K_BUS, 0, 16'h008); drain(); idle();
      Gin = 1; tick(); idle();
      Gout = 1; push(K_BUS, 0, 16'h003); drain(); idle();

      // Same-register read/write keeps R1
      Rout = 8'b0100_0000; Rin = 8'b0100_0000; tick(); idle();
      push(K_DBG, 1, 16'h007); drain();

      // 4: priority
      push_err(1'b0); drain();
      DIN = 9'h0AA; DINout = 1; Gout = 1; Rout = 8'hFF;
      push(K_BUS, 0, 16'h0AA); drain();
      tick(); idle();
      push_err(1'b1); drain();
      Gout = 1; Rout = 8'hFF; push(K_BUS, 0, 16'h003); drain(); idle();
      Rout = 8'hFF; push(K_BUS, 0, 16'h00C); drain(); idle();
      Rout = 8'h41; push(K_BUS, 0, 16'h007); drain(); idle();
      tick(); tick();
      push_err(1'b1); drain();

      // 5: Done counting and reset in the same cycle as Done
      for (int i = 1; i <= 3; i++) begin
         Done = 1; tick(); idle();
         push(K_CNT, 0, 16'(i)); drain();
      end
      Done = 1; Reset = 1; tick(); Reset = 0; idle();
      push(K_CNT, 0, 16'd0); push(K_CNT2, 0, 16'd0);
      push(K_DBG, 0, 16'd0); push(K_DBG, 1, 16'd0);
      push_err(1'b0); drain();
      for (int i = 1; i <= 4; i++) begin
         Done = 1; tick(); idle();
         push(K_CNT2, 0, 16'(i % 4)); push(K_CNT, 0, 16'(i)); drain();
      end

      // 6: IR load independent of bus
      DIN = 9'h049; IRin = 1;
      push(K_BUS, 0, 16'h000); drain();
      tick(); idle();
      push(K_IR, 0, 16'h049); push(K_BUS, 0, 16'h000); drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
